// File: rtl/rvfi_commit_serializer.sv
// Multi-lane ROB commit to single-lane RVFI serializer: in-order FIFO, 64-bit order stamping, drain handshake.
// Optional same-cycle bypass of an empty FIFO is enabled with `define RVFI_SER_BYPASS_EN.
module rvfi_commit_serializer #(
  parameter int LANES = 2,
  parameter int DEPTH = 8,
  parameter int PKT_W = 311
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [LANES-1:0]           in_valid,
  input  logic [LANES*PKT_W-1:0]     in_pkt,
  output logic                       in_ready,
  input  logic                       drain_req,
  output logic                       drain_done,
  output logic                       out_valid,
  output logic [63:0]                out_order,
  output logic [PKT_W-1:0]           out_pkt,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [$clog2(DEPTH):0]     high_water,
  output logic                       protocol_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;

  state_e             state_q, state_d;
  logic [PKT_W-1:0]   mem_q [DEPTH];
  logic [AW-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]      cnt_q, cnt_d, hw_q, hw_d;
  logic [63:0]        order_q, order_d, out_order_q, out_order_d;
  logic [PKT_W-1:0]   out_pkt_q, out_pkt_d;
  logic               out_valid_q, out_valid_d;
  logic               rdy_q, rdy_d, err_q, err_d;

  logic [CW-1:0]      k, push_cnt;
  logic               contig, gap, any_v, fits, push_ok, byp, pop, wr_en;

  // Lane count and contiguity: any valid lane above an idle one is illegal.
  always_comb begin
    k      = '0;
    contig = 1'b1;
    gap    = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (in_valid[i]) begin
        k = k + CW'(1);
        if (gap) contig = 1'b0;
      end else begin
        gap = 1'b1;
      end
    end
  end

  assign any_v   = |in_valid;
  assign fits    = (cnt_q + k) <= CW'(DEPTH);
  assign push_ok = any_v && rdy_q && contig && fits;
  assign pop     = (cnt_q != '0);

`ifdef RVFI_SER_BYPASS_EN
  assign byp = push_ok && (cnt_q == '0) && !out_valid_q && (in_valid == LANES'(1));
`else
  assign byp = 1'b0;
`endif

  assign wr_en    = push_ok && !byp;
  assign push_cnt = wr_en ? k : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + push_cnt - CW'(pop);
    wr_d    = wr_q + AW'(push_cnt);
    rd_d    = rd_q + AW'(pop);
    hw_d    = (cnt_d > hw_q) ? cnt_d : hw_q;
    err_d   = err_q | (any_v && (!contig || !rdy_q || !fits));
    unique case (state_q)
      RUN:     if (drain_req) state_d = DRAIN;
      DRAIN:   if (!drain_req) state_d = RUN;
               else if (cnt_d == '0) state_d = DONE;
      DONE:    if (!drain_req) state_d = RUN;
      default: state_d = RUN;
    endcase
    rdy_d       = (state_d == RUN) && ((CW'(DEPTH) - cnt_d) >= CW'(LANES));
    order_d     = order_q + 64'(pop | byp);
    out_valid_d = pop;
    // While idle the order output previews the next number to be stamped.
    out_order_d = pop ? order_q : order_d;
    out_pkt_d   = out_pkt_q;
    if (pop)      out_pkt_d = mem_q[rd_q];
    else if (byp) out_pkt_d = in_pkt[PKT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      hw_q        <= '0;
      err_q       <= 1'b0;
      rdy_q       <= 1'b0;
      order_q     <= '0;
      out_order_q <= '0;
      out_pkt_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      hw_q        <= hw_d;
      err_q       <= err_d;
      rdy_q       <= rdy_d;
      order_q     <= order_d;
      out_order_q <= out_order_d;
      out_pkt_q   <= out_pkt_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Storage needs no reset; only lanes below k are written, in lane order.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (CW'(i) < k) mem_q[wr_q + AW'(i)] <= in_pkt[i*PKT_W +: PKT_W];
      end
    end
  end

  assign in_ready     = rdy_q;
  assign drain_done   = (state_q == DONE);
  assign occupancy    = cnt_q;
  assign high_water   = hw_q;
  assign protocol_err = err_q;
  assign out_valid    = out_valid_q | byp;
  assign out_pkt      = byp ? in_pkt[PKT_W-1:0] : out_pkt_q;
  assign out_order    = byp ? order_q : out_order_q;

endmodule

// File: tb/tb_rvfi_commit_serializer.sv
// Scoreboard bench for rvfi_commit_serializer: stimulus queues expected {order, pkt}, a negedge monitor checks emissions.
module tb_rvfi_commit_serializer;
  localparam int LANES = 2;
  localparam int DEPTH = 8;
  localparam int PKT_W = 311;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [LANES-1:0]       in_valid = '0;
  logic [LANES*PKT_W-1:0] in_pkt = '0;
  logic                   in_ready;
  logic                   drain_req = 1'b0;
  logic                   drain_done;
  logic                   out_valid;
  logic [63:0]            out_order;
  logic [PKT_W-1:0]       out_pkt;
  logic [CW-1:0]          occupancy, high_water;
  logic                   protocol_err;

  typedef struct packed {
    logic [63:0]      order;
    logic [PKT_W-1:0] pkt;
  } exp_t;

  exp_t        sbq[$];
  logic [63:0] exp_ord = '0;
  int          next_id = 1;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  rvfi_commit_serializer #(.LANES(LANES), .DEPTH(DEPTH), .PKT_W(PKT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pkt(in_pkt), .in_ready(in_ready),
    .drain_req(drain_req), .drain_done(drain_done), .out_valid(out_valid),
    .out_order(out_order), .out_pkt(out_pkt), .occupancy(occupancy),
    .high_water(high_water), .protocol_err(protocol_err)
  );

  function automatic logic [PKT_W-1:0] mk(int id);
    logic [319:0] t;
    for (int j = 0; j < 10; j++) t[j*32 +: 32] = 32'(id) * 32'h9E3779B1 + 32'(j);
    return t[PKT_W-1:0];
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Drive contiguous lanes and queue each packet's expected order stamp.
  task automatic drive(logic [LANES-1:0] v);
    in_valid = v;
    for (int i = 0; i < LANES; i++) begin
      if (v[i]) begin
        in_pkt[i*PKT_W +: PKT_W] = mk(next_id);
        sbq.push_back({exp_ord, mk(next_id)});
        exp_ord++;
        next_id++;
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_emit: got order %0d expected no packet", out_order);
      end else begin
        e = sbq.pop_front();
        if (out_order !== e.order || out_pkt !== e.pkt) begin
          errors++;
          $display("FAIL emit: got order %0d pkt[31:0] %0h expected order %0d pkt[31:0] %0h",
                   out_order, out_pkt[31:0], e.order, e.pkt[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int pairs, stalls, cyc;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_order", out_order, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_high_water", high_water, 0);
    chk("rst_protocol_err", protocol_err, 0);
    chk("rst_drain_done", drain_done, 0);
    rst = 1'b0;
    step();
    chk("ready_after_rst", in_ready, 1);

    // Single lane, then a second packet a few cycles later.
    drive(2'b01);
`ifdef RVFI_SER_BYPASS_EN
    #1 chk("byp_same_cycle", out_valid, 1);
    step();
    in_valid = '0;
    step();
`else
    step();
    in_valid = '0;
    chk("single_occ", occupancy, 1);
    step();
    chk("single_valid", out_valid, 1);
    chk("single_order", out_order, 0);
`endif
    step(); step();
    drive(2'b01);
    step();
    in_valid = '0;
    repeat (3) step();
    chk("idle_valid", out_valid, 0);
    chk("idle_next_order", out_order, 2);

    // Dual-lane burst: occupancy climbs 2,3,4,5.
    repeat (4) begin drive(2'b11); step(); end
    in_valid = '0;
    chk("burst_occ", occupancy, 5);
    chk("burst_hw", high_water, 5);
    chk("burst_ready", in_ready, 1);
    repeat (8) step();
    chk("burst_empty", occupancy, 0);

    // Full boundary: 8 pairs, in_ready must gate at occupancy 7.
    pairs = 0; stalls = 0; cyc = 0;
    while (pairs < 8 && cyc < 100) begin
      if (in_ready) begin drive(2'b11); pairs++; end
      else begin in_valid = '0; stalls++; end
      step();
      cyc++;
      if (occupancy == CW'(7)) chk("full_ready_low", in_ready, 0);
    end
    in_valid = '0;
    chk("full_all_pushed", pairs, 8);
    chk("full_stalls", stalls, 2);
    chk("full_hw", high_water, 7);
    chk("full_no_err", protocol_err, 0);
    repeat (10) step();
    chk("full_empty", occupancy, 0);

    // Drain with 5 entries queued.
    repeat (4) begin drive(2'b11); step(); end
    in_valid = '0;
    drain_req = 1'b1;
    chk("drain_start_occ", occupancy, 5);
    step();
    chk("drain_ready_low", in_ready, 0);
    repeat (3) step();
    chk("drain_not_done", drain_done, 0);
    chk("drain_occ1", occupancy, 1);
    step();
    chk("drain_done", drain_done, 1);
    chk("drain_occ0", occupancy, 0);
    chk("drain_ready_still_low", in_ready, 0);
    drain_req = 1'b0;
    step();
    chk("undrain_done", drain_done, 0);
    chk("undrain_ready", in_ready, 1);

    // Non-contiguous lanes: flagged, nothing written.
    step();
    in_valid = 2'b10;
    in_pkt[PKT_W +: PKT_W] = mk(999);
    step();
    in_valid = '0;
    chk("perr_set", protocol_err, 1);
    chk("perr_occ", occupancy, 0);
    step(); step();
    chk("perr_sticky", protocol_err, 1);
    chk("perr_occ_later", occupancy, 0);

    // Reset mid-burst with 4 entries queued.
    repeat (3) begin drive(2'b11); step(); end
    in_valid = '0;
    chk("mid_occ", occupancy, 4);
    rst = 1'b1;
    sbq.delete();
    exp_ord = '0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_occ", occupancy, 0);
    chk("mid_rst_order", out_order, 0);
    chk("mid_rst_err", protocol_err, 0);
    step();
    rst = 1'b0;
    step();
    drive(2'b01);
`ifdef RVFI_SER_BYPASS_EN
    #1 chk("post_rst_byp", out_valid, 1);
`endif
    step();
    in_valid = '0;
    repeat (3) step();
    chk("sb_drained", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
